// File: rtl/dm_load_unit_pkg.sv
// rtl/dm_load_unit_pkg.sv - shared load-op encodings and exception record states
package dm_load_unit_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_HU = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_B  = 3'b100
    } ld_op_e;

    typedef enum logic {
        REC_CLEAR   = 1'b0,
        REC_PENDING = 1'b1
    } rec_state_e;

    // Encodings 101..111 are not loads and must never reach write-back.
    function automatic logic ld_op_legal(input logic [2:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// rtl/dm_load_unit_if.sv - MEM-stage load inputs, write-back outputs and exception record
interface dm_load_unit_if;
    import dm_load_unit_pkg::*;

    logic             stall;
    logic             flush;
    logic             ld_valid;
    logic [2:0]       ld_op;
    logic [XLEN-1:0]  DMA;
    logic [XLEN-1:0]  DM;
    logic [XLEN-1:0]  PC;
    logic [REG_W-1:0] rd;
    logic             exc_ack;

    logic             wb_we;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             exc_pend;
    logic [XLEN-1:0]  exc_epc;
    logic [XLEN-1:0]  exc_badvaddr;

    modport master (
        output stall, flush, ld_valid, ld_op, DMA, DM, PC, rd, exc_ack,
        input  wb_we, wb_rd, wb_data, exc_pend, exc_epc, exc_badvaddr
    );

    modport slave (
        input  stall, flush, ld_valid, ld_op, DMA, DM, PC, rd, exc_ack,
        output wb_we, wb_rd, wb_data, exc_pend, exc_epc, exc_badvaddr
    );

endinterface

// File: rtl/dm_load_unit_load_extract.sv
// rtl/dm_load_unit_load_extract.sv - combinational lane select, extension and alignment check
module load_extract
    import dm_load_unit_pkg::*;
(
    input  logic [2:0]      ld_op_i,
    input  logic [1:0]      addr_i,
    input  logic [XLEN-1:0] dm_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_i[1] ? dm_i[31:16] : dm_i[15:0];

        case (addr_i)
            2'b00:   byte_sel = dm_i[7:0];
            2'b01:   byte_sel = dm_i[15:8];
            2'b10:   byte_sel = dm_i[23:16];
            default: byte_sel = dm_i[31:24];
        endcase

        data_o       = '0;
        misaligned_o = 1'b0;
        case (ld_op_i)
            LD_W: begin
                data_o       = dm_i;
                misaligned_o = (addr_i != 2'b00);
            end
            LD_HU: begin
                data_o       = {16'h0000, half_sel};
                misaligned_o = addr_i[0];
            end
            LD_H: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = addr_i[0];
            end
            LD_BU:   data_o = {24'h000000, byte_sel};
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - MEM/WB load register with stall/flush and sticky address-error record
module dm_load_unit
    import dm_load_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    dm_load_unit_if.slave bus
);

    logic [XLEN-1:0]  ext_data;
    logic             ext_misaligned;
    logic             accept;
    logic             load_ok;
    logic             fault;

    logic             wb_we_q,   wb_we_d;
    logic [REG_W-1:0] wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;

    rec_state_e       state_q;
    logic [XLEN-1:0]  epc_q;
    logic [XLEN-1:0]  badvaddr_q;

    load_extract u_extract (
        .ld_op_i      (bus.ld_op),
        .addr_i       (bus.DMA[1:0]),
        .dm_i         (bus.DM),
        .data_o       (ext_data),
        .misaligned_o (ext_misaligned)
    );

    assign accept  = bus.ld_valid && ld_op_legal(bus.ld_op) && !bus.stall && !bus.flush;
    assign load_ok = accept && !ext_misaligned;
    assign fault   = accept && ext_misaligned;

    // Flush beats stall; anything other than a clean accept becomes a bubble.
    always_comb begin
        wb_we_d   = wb_we_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (bus.flush || !bus.stall) begin
            wb_we_d   = load_ok;
            wb_rd_d   = load_ok ? bus.rd : '0;
            wb_data_d = load_ok ? ext_data : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // A fault arriving with the acknowledge replaces the record rather than being lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= REC_CLEAR;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            case (state_q)
                REC_CLEAR: begin
                    if (fault) begin
                        state_q    <= REC_PENDING;
                        epc_q      <= bus.PC;
                        badvaddr_q <= bus.DMA;
                    end
                end
                REC_PENDING: begin
                    if (bus.exc_ack) begin
                        if (fault) begin
                            epc_q      <= bus.PC;
                            badvaddr_q <= bus.DMA;
                        end else begin
                            state_q <= REC_CLEAR;
                        end
                    end
                end
                default: state_q <= REC_CLEAR;
            endcase
        end
    end

    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.exc_pend     = (state_q == REC_PENDING);
    assign bus.exc_epc      = epc_q;
    assign bus.exc_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - directed and random checks of dm_load_unit against a reference model
module tb_dm_load_unit;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    dm_load_unit_if bus();

    dm_load_unit dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_pend;
    logic [31:0] m_epc;
    logic [31:0] m_bad;

    function automatic void ref_load(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [31:0] dm, output bit legal,
                                     output bit mis, output logic [31:0] data);
        int unsigned a;
        int unsigned v;
        a     = addr % 4;
        legal = 1;
        mis   = 0;
        v     = 0;
        case (op)
            3'd0: begin v = dm; mis = (a != 0); end
            3'd1, 3'd2: begin
                v   = (dm >> (16 * (a / 2))) & 32'h0000FFFF;
                mis = (a % 2) != 0;
                if (op == 3'd2 && v >= 32768) v = v + 32'hFFFF0000;
            end
            3'd3, 3'd4: begin
                v = (dm >> (8 * a)) & 32'h000000FF;
                if (op == 3'd4 && v >= 128) v = v + 32'hFFFFFF00;
            end
            default: legal = 0;
        endcase
        data = v;
    endfunction

    task automatic model_update();
        bit          legal, mis, acc;
        logic [31:0] data;
        if (reset) begin
            m_we = 0; m_rd = 0; m_data = 0; m_pend = 0; m_epc = 0; m_bad = 0;
            return;
        end
        ref_load(bus.ld_op, bus.DMA, bus.DM, legal, mis, data);
        acc = bus.ld_valid && legal && !bus.stall && !bus.flush;
        if (bus.flush || !bus.stall) begin
            m_we   = acc && !mis;
            m_rd   = (acc && !mis) ? bus.rd : 5'd0;
            m_data = (acc && !mis) ? data : 32'd0;
        end
        if (acc && mis && (!m_pend || bus.exc_ack)) begin
            m_pend = 1; m_epc = bus.PC; m_bad = bus.DMA;
        end else if (bus.exc_ack) begin
            m_pend = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_we"},    {31'd0, bus.wb_we},    {31'd0, m_we});
        chk({tag, ".wb_rd"},    {27'd0, bus.wb_rd},    {27'd0, m_rd});
        chk({tag, ".wb_data"},  bus.wb_data,           m_data);
        chk({tag, ".exc_pend"}, {31'd0, bus.exc_pend}, {31'd0, m_pend});
        chk({tag, ".exc_epc"},  bus.exc_epc,           m_epc);
        chk({tag, ".exc_bad"},  bus.exc_badvaddr,      m_bad);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    task automatic set_ld(input bit v, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] pc, input logic [4:0] r);
        bus.ld_valid = v; bus.ld_op = op; bus.DMA = a; bus.DM = d; bus.PC = pc; bus.rd = r;
    endtask

    task automatic set_ctl(input bit st, input bit fl, input bit ack, input bit rst);
        bus.stall = st; bus.flush = fl; bus.exc_ack = ack; reset = rst;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        m_we = 0; m_rd = 0; m_data = 0; m_pend = 0; m_epc = 0; m_bad = 0;

        set_ld(0, 3'd0, 0, 0, 0, 0);
        set_ctl(0, 0, 0, 1);
        step("reset0");
        step("reset1");
        chk("reset.wb_data", bus.wb_data, 32'h0);

        set_ctl(0, 0, 0, 0);
        set_ld(1, 3'd4, 32'h00000102, 32'h8081F2F3, 32'h100, 5'd3);
        step("lb");
        chk("lb.const", bus.wb_data, 32'hFFFFFF81);
        set_ld(1, 3'd3, 32'h00000102, 32'h8081F2F3, 32'h104, 5'd4);
        step("lbu");
        chk("lbu.const", bus.wb_data, 32'h00000081);
        set_ld(1, 3'd2, 32'h00000100, 32'h8081F2F3, 32'h108, 5'd5);
        step("lh");
        chk("lh.const", bus.wb_data, 32'hFFFFF2F3);
        set_ld(1, 3'd1, 32'h00000102, 32'h8081F2F3, 32'h10C, 5'd6);
        step("lhu");
        chk("lhu.const", bus.wb_data, 32'h00008081);
        set_ld(1, 3'd0, 32'h00000010, 32'h12345678, 32'h110, 5'd8);
        step("lw");
        chk("lw.const", bus.wb_data, 32'h12345678);
        chk("lw.rd", {27'd0, bus.wb_rd}, 32'd8);

        for (int i = 0; i < 3; i++) begin
            set_ctl(1, 0, 0, 0);
            set_ld(1, 3'(i + 2), $urandom, $urandom, $urandom, 5'(i + 20));
            step("stall");
            chk("stall.hold", bus.wb_data, 32'h12345678);
        end

        set_ctl(1, 1, 0, 0);
        set_ld(1, 3'd0, 32'h20, 32'hCAFEF00D, 32'h200, 5'd9);
        step("flush_stall");
        chk("flush_stall.we", {31'd0, bus.wb_we}, 32'd0);

        set_ctl(0, 0, 0, 0);
        set_ld(1, 3'd0, 32'h00000006, 32'hDEADBEEF, 32'h00003010, 5'd10);
        step("fault1");
        chk("fault1.epc", bus.exc_epc, 32'h00003010);
        chk("fault1.bad", bus.exc_badvaddr, 32'h00000006);
        set_ld(1, 3'd2, 32'h00000001, 32'h0, 32'h00003020, 5'd11);
        step("fault2_kept");
        chk("fault2.epc", bus.exc_epc, 32'h00003010);

        set_ld(0, 3'd0, 0, 0, 0, 0);
        set_ctl(0, 0, 1, 0);
        step("ack");
        chk("ack.pend", {31'd0, bus.exc_pend}, 32'd0);

        set_ctl(0, 0, 0, 0);
        set_ld(1, 3'd0, 32'h0000000B, 32'h0, 32'h00003030, 5'd12);
        step("fault3");
        set_ctl(0, 0, 1, 0);
        set_ld(1, 3'd1, 32'h00000021, 32'h0, 32'h00003040, 5'd13);
        step("ack_fault");
        chk("ack_fault.epc", bus.exc_epc, 32'h00003040);
        chk("ack_fault.pend", {31'd0, bus.exc_pend}, 32'd1);

        set_ctl(0, 0, 0, 0);
        set_ld(1, 3'd0, 32'h00000040, 32'h55AA55AA, 32'h3050, 5'd14);
        step("held_entry");
        set_ctl(1, 0, 0, 1);
        step("reset_mid_stall");
        chk("reset_mid_stall.we", {31'd0, bus.wb_we}, 32'd0);
        chk("reset_mid_stall.pend", {31'd0, bus.exc_pend}, 32'd0);

        set_ctl(0, 0, 0, 0);
        set_ld(1, 3'd7, 32'h00000003, 32'hFFFFFFFF, 32'h3060, 5'd15);
        step("illegal_op");
        chk("illegal_op.pend", {31'd0, bus.exc_pend}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
            set_ld($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, 5'($urandom_range(0, 31)));
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dm_load_unit.md
# dm_load_unit

Load-side counterpart of the data memory store path: it takes the combinational word read from DM in the MEM stage and produces the write-back value for lw/lh/lhu/lb/lbu. The block holds the MEM/WB load pipeline register, with stall and flush, and detects misaligned loads. A misaligned load raises a sticky address-error record (EPC and BadVAddr) that is held until acknowledged. It sits between DM and the register-file write port in the pipelined CPU.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register index.
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- stall  in  1  hold the WB register contents (MEM/WB enable low)
- flush  in  1  clear the WB register to a bubble; a flush coincident with stall wins
- ld_valid  in  1  a load instruction is in MEM this cycle
- ld_op  in  3  000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb; 101-111 illegal, treated as no load
- DMA  in  32  byte address of the load
- DM  in  32  word read from DM at DMA[13:2]
- PC  in  32  PC of the MEM-stage instruction
- rd  in  5  destination register
- wb_we  out  1  register-file write enable
- wb_rd  out  5  write-back register index
- wb_data  out  32  extended load data
- exc_pend  out  1  sticky address-error flag
- exc_epc  out  32  PC of the faulting load
- exc_badvaddr  out  32  faulting address
- exc_ack  in  1  clears the sticky record

## Operation
- Extraction:
  - Half-word select uses DMA[1]: 0 selects [15:0], 1 selects [31:16].
  - Byte select uses DMA[1:0]: 00 selects [7:0] through 11 selects [31:24].
  - lhu and lbu zero-extend; lh and lb sign-extend from bit 15 or bit 7.
- Alignment rules:
  - lw requires DMA[1:0]==00.
  - lh and lhu require DMA[0]==0.
  - Byte loads are always aligned.
- A load is accepted when ld_valid=1, ld_op is legal, stall=0 and flush=0.
- An accepted aligned load registers wb_we=1, wb_rd=rd and wb_data=extracted value.
  - rd==0 still writes wb_rd=0 with wb_we=1; the register file ignores $0.
- An accepted misaligned load registers a bubble (wb_we=0, wb_rd=0, wb_data=0).
  - If exc_pend=0, it also sets exc_pend=1 and latches exc_epc=PC and exc_badvaddr=DMA.
  - If exc_pend=1, the record is left untouched; the first fault is kept.
- A cycle with no accepted load (ld_valid=0 or illegal op) and no stall registers a bubble.
- Record state machine has two states:
  - CLEAR: a misaligned accept moves to PENDING.
  - PENDING: exc_ack=1 moves to CLEAR.
  - If exc_ack and a new misaligned accept occur in the same cycle, the new fault is latched and the state stays PENDING.

## Timing
- Latency is 1 cycle: wb_* reflect the MEM inputs sampled at the preceding posedge.
- stall=1 holds wb_* unchanged, including wb_we.
- stall does not block exc_ack. A misaligned load during stall is not accepted and raises no exception.
- flush=1 registers a bubble regardless of stall and raises no exception.
- Reset values: wb_we=0, wb_rd=0, wb_data=0, exc_pend=0, exc_epc=0, exc_badvaddr=0, state CLEAR. Reset overrides stall, flush and exc_ack.
- Reset asserted mid-stall discards the held entry.
- exc_* are registered outputs; exc_pend rises 1 cycle after the faulting load is accepted.

## Structure
- The shared CPU package holds the ld_op encodings (LD_W, LD_HU, LD_H, LD_BU, LD_B) and the record state constants.
- Sub-module load_extract: purely combinational (ld_op, DMA[1:0], DM) -> (data, misaligned). It is instantiated once and is reusable by the forwarding logic.
- The top module holds the WB register, stall/flush priority and the exception record FSM.

## Test plan
- Extension:
  - DM=0x8081F2F3, DMA=0x...2, lb -> wb_data=0xFFFFFF81 one cycle later.
  - Same DM and DMA, lbu -> 0x00000081.
  - Same DM, lh at DMA=0x...0 -> 0xFFFFF2F3.
  - Same DM, lhu at DMA=0x...2 -> 0x00008081.
- lw at DMA=0x00000010, DM=0x12345678, rd=8 -> wb_we=1, wb_rd=8, wb_data=0x12345678.
- Stall/flush:
  - Load, then stall for 3 cycles while inputs change -> wb_* constant.
  - flush+stall together -> bubble.
- Faults:
  - lw at DMA=0x00000006, PC=0x00003010 -> bubble, exc_pend=1, epc=0x00003010, badvaddr=0x00000006.
  - A second fault before ack -> record unchanged.
  - exc_ack -> exc_pend=0 next cycle.
  - exc_ack coincident with a new fault -> new record latched, exc_pend stays 1.
- Boundaries:
  - Reset asserted during PENDING with a held WB entry -> all outputs 0 next cycle.
  - ld_op=111 with ld_valid=1 -> bubble, no exception.
